lsu: RTL



---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication and byte enables, load extraction and
// extension, misalignment detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o       = BE_WORD;
        wdata_o    = wd_i;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        byte_sel   = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // Size 2'b11 falls into the word branch.
        case (mem_size_t'(size_i))
            SZ_B: begin
                rdata_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
                if (we_i) begin
                    be_o    = BE_BYTE << addr_lo_i;
                    wdata_o = {4{wd_i[7:0]}};
                end
            end
            SZ_H: begin
                misalign_o = addr_lo_i[0];
                rdata_o    = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
                if (we_i) begin
                    be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                    wdata_o = {2{wd_i[15:0]}};
                end
            end
            default: begin
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request/grant/rvalid bus master for the writeback-stage memory access,
// with pipeline stall and extended load result.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReqW,
    input  logic              MemWrW,
    input  logic [1:0]        MemSizeW,
    input  logic              MemUnsignedW,
    input  logic [ADDR_W-1:0] AddrW,
    input  logic [31:0]       WD,
    output logic              StallLSU,
    output logic [31:0]       ReadData,
    output logic              LoadValid,
    output logic              MisalignW,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              hold_we_q, hold_we_d;
    logic [1:0]        hold_size_q, hold_size_d;
    logic              hold_uns_q, hold_uns_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [31:0]       hold_wd_q, hold_wd_d;
    logic [31:0]       read_data_q, read_data_d;

    logic              idle;
    logic              cur_we;
    logic [1:0]        cur_size;
    logic              cur_uns;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wd;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       rdata_ext;
    logic              misalign;

    // Live inputs drive the bus only in IDLE; afterwards the held copy is used.
    assign idle     = (state_q == IDLE);
    assign cur_we   = idle ? MemWrW       : hold_we_q;
    assign cur_size = idle ? MemSizeW     : hold_size_q;
    assign cur_uns  = idle ? MemUnsignedW : hold_uns_q;
    assign cur_addr = idle ? AddrW        : hold_addr_q;
    assign cur_wd   = idle ? WD           : hold_wd_q;

    lsu_align u_align (
        .size_i     (cur_size),
        .unsigned_i (cur_uns),
        .addr_lo_i  (cur_addr[1:0]),
        .we_i       (cur_we),
        .wd_i       (cur_wd),
        .rdata_i    (mem_rdata),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (rdata_ext),
        .misalign_o (misalign)
    );

    always_comb begin
        state_d     = state_q;
        hold_we_d   = hold_we_q;
        hold_size_d = hold_size_q;
        hold_uns_d  = hold_uns_q;
        hold_addr_d = hold_addr_q;
        hold_wd_d   = hold_wd_q;
        read_data_d = read_data_q;
        mem_req     = 1'b0;
        StallLSU    = 1'b0;
        LoadValid   = 1'b0;
        MisalignW   = 1'b0;

        unique case (state_q)
            IDLE: begin
                hold_we_d   = MemWrW;
                hold_size_d = MemSizeW;
                hold_uns_d  = MemUnsignedW;
                hold_addr_d = AddrW;
                hold_wd_d   = WD;
                if (MemReqW) begin
                    if (misalign) begin
                        MisalignW = 1'b1;
                    end else begin
                        mem_req = 1'b1;
                        if (!mem_gnt) begin
                            StallLSU = 1'b1;
                            state_d  = WAIT_GNT;
                        end else if (!MemWrW) begin
                            StallLSU = 1'b1;
                            state_d  = WAIT_RVALID;
                        end
                    end
                end
            end
            WAIT_GNT: begin
                mem_req = 1'b1;
                if (!mem_gnt) begin
                    StallLSU = 1'b1;
                end else if (hold_we_q) begin
                    state_d = IDLE;
                end else begin
                    StallLSU = 1'b1;
                    state_d  = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (mem_rvalid) begin
                    LoadValid   = 1'b1;
                    read_data_d = rdata_ext;
                    state_d     = IDLE;
                end else begin
                    StallLSU = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_we    = mem_req & cur_we;
    assign mem_addr  = mem_req ? {cur_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be    = mem_req ? lane_be : 4'b0000;
    assign mem_wdata = mem_req ? lane_wdata : 32'h0;
    assign ReadData  = LoadValid ? rdata_ext : read_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_we_q   <= 1'b0;
            hold_size_q <= 2'b00;
            hold_uns_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_wd_q   <= 32'h0;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            hold_we_q   <= hold_we_d;
            hold_size_q <= hold_size_d;
            hold_uns_q  <= hold_uns_d;
            hold_addr_q <= hold_addr_d;
            hold_wd_q   <= hold_wd_d;
            read_data_q <= read_data_d;
        end
    end

endmodule
